// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from instruction memory, holds the
// instruction for control/datapath and computes sequential, branch and jump targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT     = 16,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        pcupdate,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        state, state_nxt;
    logic [CW-1:0] tcnt;
    logic [31:0]   pc_plus4;
    logic [31:0]   br_off;
    logic [31:0]   pc_next;
    logic          is_halt;

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign is_halt   = (imem_rdata[31:26] == HALT_OPCODE);

    // Jump beats branch; a branch is only taken when the ALU reports equality.
    always_comb begin
        pc_next = pc_plus4;
        if (jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && alu_zero)
            pc_next = pc_plus4 + br_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid)
                    state_nxt = is_halt ? HALT : HOLD;
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (pcupdate)
                    state_nxt = FETCH;
            end
            HALT: instr_valid = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            instr     <= '0;
            tcnt      <= '0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (pcupdate)
                        fetch_err <= 1'b1;
                end
                FETCH: begin
                    if (pcupdate)
                        fetch_err <= 1'b1;
                    if (imem_valid) begin
                        instr <= imem_rdata;
                        if (is_halt)
                            halted <= 1'b1;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        // Saturate and keep requesting; the error is sticky.
                        fetch_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (pcupdate) begin
                        pc   <= pc_next;
                        tcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch/hold/halt rules.
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic        pcupdate = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic        instr_valid;
    logic        halted;
    logic        fetch_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: where the unit is in its life cycle, expressed as plain flags and counts.
    logic [31:0] m_pc, m_instr;
    bit          m_started, m_have, m_halt, m_err;
    int          m_miss;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .TIMEOUT    (TIMEOUT),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .pcupdate   (pcupdate),
        .jump       (jump),
        .branch     (branch),
        .alu_zero   (alu_zero),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .instr_valid(instr_valid),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] model_next_pc();
        logic [31:0] pc4;
        int          off;
        pc4 = m_pc + 32'd4;
        off = int'($signed(m_instr[15:0]));
        if (jump)
            return (pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
        if (branch && alu_zero)
            return pc4 + 32'(off * 4);
        return pc4;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0;
        m_started = 0; m_have = 0; m_halt = 0; m_err = 0; m_miss = 0;
    endtask

    task automatic model_step();
        logic [5:0] op;
        op = imem_rdata[31:26];
        if (!m_started) begin
            m_started = 1;
            m_miss = 0;
            if (pcupdate) m_err = 1;
        end else if (m_halt) begin
            // frozen until reset
        end else if (!m_have) begin
            if (pcupdate) m_err = 1;
            if (imem_valid) begin
                m_instr = imem_rdata;
                if (op == 6'h3F) m_halt = 1;
                else             m_have = 1;
            end else begin
                m_miss++;
                if (m_miss >= TIMEOUT) m_err = 1;
            end
        end else if (pcupdate) begin
            m_pc   = model_next_pc();
            m_have = 0;
            m_miss = 0;
        end
    endtask

    task automatic compare_all();
        bit fetching;
        fetching = m_started && !m_have && !m_halt;
        check("imem_req",    {31'b0, imem_req},    {31'b0, fetching});
        check("imem_addr",   imem_addr,            m_pc);
        check("pc",          pc,                   m_pc);
        check("instr",       instr,                m_instr);
        check("opcode",      {26'b0, opcode},      {26'b0, m_instr[31:26]});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, (m_have || m_halt)});
        check("halted",      {31'b0, halted},      {31'b0, m_halt});
        check("fetch_err",   {31'b0, fetch_err},   {31'b0, m_err});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset lands mid-cycle and must take effect before any clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        pcupdate = 0; jump = 0; branch = 0; alu_zero = 0; imem_valid = 0;
        #1;
        model_reset();
        check("rst_pc",   pc,                   32'h0);
        check("rst_iv",   {31'b0, instr_valid}, 32'h0);
        check("rst_req",  {31'b0, imem_req},    32'h0);
        check("rst_inst", instr,                32'h0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] w, input int lat);
        for (int i = 0; i < lat; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            tick();
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        tick();
        imem_valid = 1'b0;
    endtask

    task automatic update(input logic j, input logic b, input logic z);
        pcupdate = 1'b1; jump = j; branch = b; alu_zero = z;
        tick();
        pcupdate = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;

        // Reset release and a 2-cycle-latency fetch from address 0.
        apply_reset();
        tick();
        check("tp1_req_c1", {31'b0, imem_req}, 32'h1);
        check("tp1_addr",   imem_addr,         32'h0);
        fetch(32'h2008_0005, 1);
        check("tp1_instr",  instr,                32'h2008_0005);
        check("tp1_opcode", {26'b0, opcode},      32'h08);
        check("tp1_iv",     {31'b0, instr_valid}, 32'h1);
        update(0, 0, 0);
        check("tp1_pc4",    pc,                   32'h4);
        check("tp1_req",    {31'b0, imem_req},    32'h1);

        // Walk to 0x10, then taken and not-taken BEQ.
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0, 0);
            update(0, 0, 0);
        end
        check("br_start", pc, 32'h10);
        fetch(32'h1000_FFFE, 0);
        update(0, 1, 1);
        check("br_taken", pc, 32'h0C);
        fetch(32'h0, 0);
        update(0, 0, 0);
        fetch(32'h1000_FFFE, 0);
        update(0, 1, 0);
        check("br_not_taken", pc, 32'h14);

        // Reach the 0xF region by a wrapping backward branch, then jump.
        apply_reset();
        tick();
        fetch(32'h1000_8000, 0);
        update(0, 1, 1);
        check("br_wrap", pc, 32'hFFFE_0004);
        fetch(32'h0800_0010, 0);
        update(1, 0, 0);
        check("jmp_region", pc, 32'hF000_0040);
        fetch(32'h0800_0010, 0);
        update(1, 1, 1);
        check("jmp_over_br", pc, 32'hF000_0040);

        // Halt opcode: sticky, no requests, pcupdate ignored without error.
        fetch(32'hFC00_0000, 2);
        check("halt_flag", {31'b0, halted},   32'h1);
        check("halt_req",  {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b1;
            update(1'($urandom), 1'($urandom), 1'($urandom));
        end
        imem_valid = 1'b0;
        check("halt_pc",  pc,                 32'hF000_0040);
        check("halt_err", {31'b0, fetch_err}, 32'h0);

        // Timeout: 15 empty cycles are tolerated, the 16th flags the error.
        apply_reset();
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("to_early", {31'b0, fetch_err}, 32'h0);
        tick();
        check("to_err", {31'b0, fetch_err}, 32'h1);
        check("to_req", {31'b0, imem_req},  32'h1);
        repeat (3) tick();

        // pcupdate during FETCH is a protocol violation.
        apply_reset();
        tick();
        update(0, 0, 0);
        check("viol_err", {31'b0, fetch_err}, 32'h1);
        check("viol_pc",  pc,                 32'h0);

        // Reset while holding at 0x20.
        apply_reset();
        tick();
        fetch(32'h0800_0008, 0);
        update(1, 0, 0);
        check("mid_pc", pc, 32'h20);
        fetch(32'h2008_0005, 1);
        apply_reset();
        check("mid_idle_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("mid_fetch_req",  {31'b0, imem_req}, 32'h1);
        check("mid_fetch_addr", imem_addr,         32'h0);

        // Randomized traffic, including stray valids and protocol violations.
        for (int n = 0; n < 2000; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 49) == 0) apply_reset();
            op = ($urandom_range(0, 39) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
            imem_rdata = {op, 26'($urandom)};
            imem_valid = ($urandom_range(0, 2) == 0);
            pcupdate   = ($urandom_range(0, 2) == 0);
            jump       = ($urandom_range(0, 3) == 0);
            branch     = 1'($urandom);
            alu_zero   = 1'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
